// File: rtl/gmii_tx_framer_pkg.sv
// Shared constants and types for the GMII transmit framer.
package gmii_tx_framer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam int unsigned ENTRY_W       = 10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_IFG  = 3'd4
    } state_t;

    typedef struct packed {
        logic       last;
        logic       er;
        logic [7:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head and occupancy count.
module sync_byte_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned AW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_idx;
    logic [AW:0]      w_remain;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_head;

    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;
    assign w_rd_idx = r_rd_ptr + AW'(w_pop);
    assign w_remain = r_count - (AW+1)'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Head is either the entry behind the popped one or, when that slot is empty, the incoming write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            r_rd_ptr <= w_rd_idx;
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_push && (w_remain == '0)) begin
                r_head <= i_wr_data;
            end else if (w_remain != '0) begin
                r_head <= r_mem[w_rd_idx];
            end
        end
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: buffers frames, prepends preamble/SFD and enforces the inter-frame gap.
// Frame/drop counters are built only when GMII_TX_FRAMER_CNT_EN is defined.
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int unsigned FIFO_AW      = 6,
    parameter int unsigned IFG_BYTES    = 12,
    parameter int unsigned PREAMBLE_LEN = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_dv_i,
    input  logic        gmii_er_i,
    input  logic [7:0]  gmii_data_i,
    output logic        gmii_en_o,
    output logic        gmii_er_o,
    output logic [7:0]  gmii_data_o,
    output logic [31:0] cnt_pkt,
    output logic [31:0] cnt_drop
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic               r_armed;
    logic               r_dv;
    logic               r_er;
    logic [7:0]         r_data;
    logic               r_drop;

    state_t             r_state;
    logic [7:0]         r_cnt;
    logic               r_tail;

    logic               w_in_byte;
    logic               w_trunc;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic               w_full;
    logic [FIFO_AW:0]   w_count;
    logic [ENTRY_W-1:0] w_rd_data;
    fifo_entry_t        w_wr_entry;
    fifo_entry_t        w_head;

    // Input stage; bytes are ignored after reset until dv has been seen low once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_dv    <= 1'b0;
            r_er    <= 1'b0;
            r_data  <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_armed <= r_armed | ~gmii_dv_i;
            r_dv    <= gmii_dv_i & r_armed;
            r_er    <= gmii_er_i;
            r_data  <= gmii_data_i;
            if (w_trunc && gmii_dv_i) begin
                r_drop <= 1'b1;
            end else if (!gmii_dv_i) begin
                r_drop <= 1'b0;
            end
        end
    end

    // A byte arriving at depth-1 closes the frame as an errored tail; if the FIFO is
    // already full (only possible at a frame start) the whole frame is discarded.
    assign w_in_byte = r_dv && !r_drop;
    assign w_trunc   = w_in_byte && (w_count >= (FIFO_AW+1)'(DEPTH - 1));
    assign w_push    = w_in_byte && !w_full;

    always_comb begin
        w_wr_entry      = '0;
        w_wr_entry.last = (r_dv & ~gmii_dv_i) | w_trunc;
        w_wr_entry.er   = r_er | w_trunc;
        w_wr_entry.data = r_data;
    end

    sync_byte_fifo #(
        .WIDTH (ENTRY_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data (w_wr_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_data),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (w_count)
    );

    assign w_head = fifo_entry_t'(w_rd_data);
    assign w_pop  = (r_state == ST_SFD) || ((r_state == ST_DATA) && !r_tail);

    // Output FSM; r_state names what is being driven on the output this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tail      <= 1'b0;
            gmii_en_o   <= 1'b0;
            gmii_er_o   <= 1'b0;
            gmii_data_o <= '0;
        end else begin
            gmii_en_o   <= 1'b0;
            gmii_er_o   <= 1'b0;
            gmii_data_o <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state     <= ST_PRE;
                        r_cnt       <= 8'd1;
                        gmii_en_o   <= 1'b1;
                        gmii_data_o <= PREAMBLE_BYTE;
                    end
                end
                ST_PRE: begin
                    gmii_en_o <= 1'b1;
                    if (r_cnt == 8'(PREAMBLE_LEN)) begin
                        r_state     <= ST_SFD;
                        gmii_data_o <= SFD_BYTE;
                    end else begin
                        r_cnt       <= r_cnt + 8'd1;
                        gmii_data_o <= PREAMBLE_BYTE;
                    end
                end
                ST_SFD, ST_DATA: begin
                    if ((r_state == ST_DATA) && r_tail) begin
                        r_state <= ST_IFG;
                        r_cnt   <= 8'd1;
                        r_tail  <= 1'b0;
                    end else begin
                        r_state     <= ST_DATA;
                        r_tail      <= w_head.last;
                        gmii_en_o   <= 1'b1;
                        gmii_er_o   <= w_head.er;
                        gmii_data_o <= w_head.data;
                    end
                end
                ST_IFG: begin
                    if (r_cnt == 8'(IFG_BYTES)) begin
                        if (!w_empty) begin
                            r_state     <= ST_PRE;
                            r_cnt       <= 8'd1;
                            gmii_en_o   <= 1'b1;
                            gmii_data_o <= PREAMBLE_BYTE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef GMII_TX_FRAMER_CNT_EN
    logic [31:0] r_cnt_pkt;
    logic [31:0] r_cnt_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_pkt  <= '0;
            r_cnt_drop <= '0;
        end else begin
            if (w_pop && !w_empty && w_head.last) begin
                r_cnt_pkt <= r_cnt_pkt + 32'd1;
            end
            if (w_trunc) begin
                r_cnt_drop <= r_cnt_drop + 32'd1;
            end
        end
    end

    assign cnt_pkt  = r_cnt_pkt;
    assign cnt_drop = r_cnt_drop;
`else
    assign cnt_pkt  = '0;
    assign cnt_drop = '0;
`endif

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed self-checking bench for gmii_tx_framer (default parameters).
module tb_gmii_tx_framer;

`ifdef GMII_TX_FRAMER_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int LOGN = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv  = 1'b0;
    logic        er  = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        en_o;
    logic        er_o;
    logic [7:0]  data_o;
    logic [31:0] cnt_pkt;
    logic [31:0] cnt_drop;

    gmii_tx_framer dut (
        .clk         (clk),
        .rst         (rst),
        .gmii_dv_i   (dv),
        .gmii_er_i   (er),
        .gmii_data_i (din),
        .gmii_en_o   (en_o),
        .gmii_er_o   (er_o),
        .gmii_data_o (data_o),
        .cnt_pkt     (cnt_pkt),
        .cnt_drop    (cnt_drop)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output trace indexed by cycle number, sampled mid-cycle.
    logic       log_en  [LOGN];
    logic       log_er  [LOGN];
    logic [7:0] log_d   [LOGN];
    int         log_occ [LOGN];
    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_en[cyc]  <= en_o;
            log_er[cyc]  <= er_o;
            log_d[cyc]   <= data_o;
            log_occ[cyc] <= int'(dut.u_fifo.o_count);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dv = 1'b0; er = 1'b0; din = 8'h00;
        end
    endtask

    task automatic send(input int len, input int f, input int er_idx, output int t0);
        t0 = 0;
        for (int j = 0; j < len; j++) begin
            @(negedge clk);
            if (j == 0) t0 = cyc;
            dv = 1'b1; er = (j == er_idx); din = 8'(f * 7 + j);
        end
    endtask

    // Checks one framed output whose first input byte was driven at cycle t.
    task automatic check_frame(input string tag, input int t, input int f, input int len, input int er_idx);
        int bad = 0;
        check({tag, "_gap_before"}, 32'(log_en[t + 2]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            if (log_en[t + 3 + k] !== 1'b1 || log_er[t + 3 + k] !== 1'b0 ||
                log_d[t + 3 + k] !== ((k == 7) ? 8'hD5 : 8'h55)) bad++;
        end
        check({tag, "_preamble_bad"}, 32'(bad), 32'd0);
        bad = 0;
        for (int j = 0; j < len; j++) begin
            if (log_en[t + 11 + j] !== 1'b1 || log_d[t + 11 + j] !== 8'(f * 7 + j) ||
                log_er[t + 11 + j] !== (j == er_idx)) bad++;
        end
        check({tag, "_data_bad"}, 32'(bad), 32'd0);
        check({tag, "_en_after"}, 32'(log_en[t + 11 + len]), 32'd0);
    endtask

    initial begin
        int t1, t2, t3, ta, tr, tn, cnt, mx, tend, k, s, len, fid, prev_f, nout, ntrunc, bad;
        logic [31:0] base_pkt, base_drop, pkt_after_rst;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_en", 32'(en_o), 32'd0);
        check("rst_er", 32'(er_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_cnt_pkt", cnt_pkt, 32'd0);
        check("rst_cnt_drop", cnt_drop, 32'd0);
        rst = 1'b0;
        idle(2);

        // Single 64-byte frame 0x00..0x3F
        send(64, 0, -1, t1);
        idle(100);
        check_frame("t1", t1, 0, 64, -1);
        check("t1_first_pre", 32'(log_d[t1 + 3]), 32'h55);
        check("t1_sfd", 32'(log_d[t1 + 10]), 32'hD5);
        check("t1_byte0_at_T11", 32'(log_d[t1 + 11]), 32'h00);
        check("t1_byte63", 32'(log_d[t1 + 74]), 32'h3F);
        cnt = 0;
        for (int c = t1; c < t1 + 120; c++) if (log_en[c] === 1'b1) cnt++;
        check("t1_en_cycles", 32'(cnt), 32'd72);
        check("t1_cnt_pkt", cnt_pkt, CNT_ON ? 32'd1 : 32'd0);
        check("t1_cnt_drop", cnt_drop, 32'd0);

        // Two 60-byte frames with a 20-cycle input gap
        send(60, 1, -1, t1);
        idle(20);
        send(60, 2, -1, t2);
        idle(120);
        check_frame("t2a", t1, 1, 60, -1);
        check_frame("t2b", t2, 2, 60, -1);
        cnt = 0;
        for (int c = t1 + 71; c < t1 + 171; c++) begin
            if (log_en[c] === 1'b1) break;
            cnt++;
        end
        check("t2_ifg_len", 32'(cnt), 32'd12);
        mx = 0;
        for (int c = t1; c < t2 + 100; c++) if (log_occ[c] > mx) mx = log_occ[c];
        check("t2_occ_le20", 32'(mx <= 20), 32'd1);
        check("t2_cnt_pkt", cnt_pkt, CNT_ON ? 32'd3 : 32'd0);

        // Errored input byte 10
        send(60, 3, 10, t3);
        idle(120);
        check_frame("t3", t3, 3, 60, 10);
        check("t3_er_byte10", 32'(log_er[t3 + 21]), 32'd1);
        check("t3_data_byte10", 32'(log_d[t3 + 21]), 32'd31);
        check("t3_er_byte11", 32'(log_er[t3 + 22]), 32'd0);
        check("t3_cnt_pkt", cnt_pkt, CNT_ON ? 32'd4 : 32'd0);

        // Ten back-to-back 60-byte frames with 2-cycle gaps force overflow
        base_pkt  = cnt_pkt;
        base_drop = cnt_drop;
        ta = 0;
        for (int f = 10; f < 20; f++) begin
            send(60, f, -1, tn);
            if (f == 10) ta = tn;
            idle(2);
        end
        idle(400);
        tend = cyc - 1;
        k = ta; prev_f = 9; nout = 0; ntrunc = 0;
        while (k < tend) begin
            if (log_en[k] === 1'b1) begin
                s = k;
                while (k < tend && log_en[k] === 1'b1) k++;
                len = k - s - 8;
                bad = 0;
                for (int i = 0; i < 8; i++)
                    if (log_d[s + i] !== ((i == 7) ? 8'hD5 : 8'h55) || log_er[s + i] !== 1'b0) bad++;
                if (len < 1 || len > 60) begin
                    bad++;
                end else begin
                    fid = int'(log_d[s + 8]) / 7;
                    if (int'(log_d[s + 8]) % 7 != 0 || fid <= prev_f || fid > 19) bad++;
                    prev_f = fid;
                    for (int j = 0; j < len; j++) begin
                        if (log_d[s + 8 + j] !== 8'(fid * 7 + j)) bad++;
                        if (j < len - 1 && log_er[s + 8 + j] !== 1'b0) bad++;
                    end
                    if (log_er[s + 7 + len] === 1'b1) ntrunc++;
                    else if (len < 60) bad++;
                end
                check("t4_frame_bad", 32'(bad), 32'd0);
                nout++;
            end else begin
                k++;
            end
        end
        check("t4_truncation_seen", 32'(ntrunc >= 1), 32'd1);
        check("t4_frames_out_ge1", 32'(nout >= 1), 32'd1);
        check("t4_cnt_pkt", cnt_pkt - base_pkt, CNT_ON ? 32'(nout) : 32'd0);
        check("t4_cnt_drop", cnt_drop - base_drop, CNT_ON ? 32'(ntrunc + 10 - nout) : 32'd0);
        check("t4_cnt_drop_ge1", 32'((cnt_drop - base_drop) >= 32'd1), CNT_ON ? 32'd1 : 32'd0);

        // Reset pulsed at output data byte 20 while input is mid-frame
        tr = 0;
        pkt_after_rst = 32'hFFFF_FFFF;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j == 0) tr = cyc;
            if (j == 32) pkt_after_rst = cnt_pkt;
            dv = 1'b1; er = 1'b0; din = 8'(20 * 7 + j);
            rst = (j == 31);
        end
        idle(100);
        check("t5_byte20_en", 32'(log_en[tr + 31]), 32'd1);
        check("t5_byte20_data", 32'(log_d[tr + 31]), 32'd160);
        check("t5_idle_after_rst", 32'(log_en[tr + 32]), 32'd0);
        cnt = 0;
        for (int c = tr + 32; c < tr + 150; c++) if (log_en[c] === 1'b1) cnt++;
        check("t5_tail_ignored", 32'(cnt), 32'd0);
        check("t5_cnt_pkt_zero", pkt_after_rst, 32'd0);
        send(60, 21, -1, tn);
        idle(120);
        check_frame("t5_next", tn, 21, 60, -1);
        check("t5_cnt_pkt_one", cnt_pkt, CNT_ON ? 32'd1 : 32'd0);
        check("t5_cnt_drop", cnt_drop, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Transmit-side GMII framer placed between `gmii_crc_calculate` and `util_gmii_to_rgmii` in the 125 MHz domain. Takes frames as a contiguous byte stream (DA..FCS, no preamble). Emits each frame prefixed with 7×0x55 preamble plus a 0xD5 SFD, then enforces a minimum inter-frame gap. An internal byte FIFO absorbs the 8-byte expansion per frame. Overflowing frames are truncated and marked with `gmii_er_o`.

## Interface
- `FIFO_AW`, 6: FIFO address width; depth = 2^FIFO_AW entries.
- `IFG_BYTES`, 12: idle cycles forced after every output frame; range 1..255.
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD; range 1..15.
- `clk` in 1: 125 MHz clock; one clock only.
- `rst` in 1: synchronous, active-high reset.
- `gmii_dv_i` in 1: input frame byte valid, contiguous per frame.
- `gmii_er_i` in 1: input byte error, carried through to the output.
- `gmii_data_i` in 8: input frame byte.
- `gmii_en_o` out 1: output enable, registered.
- `gmii_er_o` out 1: output error, registered.
- `gmii_data_o` out 8: output byte, registered.
- `cnt_pkt` out 32: frames fully transmitted.
- `cnt_drop` out 32: frames truncated on overflow.

## Operation
- Input stage registers `dv`, `er` and `data` once.
- A byte is written to the FIFO from the registered stage. Entry = {last, er, data}, 10 bits.
- `last` = registered dv & ~`gmii_dv_i`. The write is delayed one cycle so the tail byte is known.
- Overflow:
  - When FIFO occupancy reaches depth−1 during a frame, that byte is written with last=1, er=1.
  - The remaining input bytes are discarded until `gmii_dv_i` goes low.
  - `cnt_drop` increments by 1.
- After reset deassertion, input is ignored until `gmii_dv_i` has been sampled low once. This prevents accepting a frame tail.
- FSM states:
  - IDLE → PRE when FIFO non-empty.
  - PRE: drive 0x55 for PREAMBLE_LEN cycles → SFD.
  - SFD: drive 0xD5 for 1 cycle → DATA.
  - DATA: pop one entry per cycle and drive data/er. When the popped entry has last=1 → IFG, and `cnt_pkt` increments (truncated frames included).
  - IFG: en=0 for IFG_BYTES cycles → IDLE. Goes straight to PRE if the FIFO is non-empty at the final IFG cycle.
- During IDLE and IFG: `gmii_en_o`=0, `gmii_er_o`=0, `gmii_data_o`=0x00.
- Underrun cannot occur. Input is contiguous, and the PRE/SFD phase guarantees ≥PREAMBLE_LEN+1 bytes are buffered before the first pop.
- Simultaneous push and pop in the same cycle: occupancy is unchanged. Full and empty are computed from a (FIFO_AW+1)-bit count.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - FIFO empty.
  - Input stage cleared.
  - Counters 0.
- Reset asserted mid-frame aborts the output immediately: `gmii_en_o`=0 on the cycle after `rst` is sampled.
- Latency from IDLE: first input byte at cycle T.
  - Write at T+1.
  - FIFO non-empty at T+2.
  - First 0x55 on output at T+3.
  - SFD at T+3+PREAMBLE_LEN.
  - Data byte N at T+4+PREAMBLE_LEN+N (T+11+N with defaults).
- Steady state: the FIFO grows by (PREAMBLE_LEN+1+IFG_BYTES − G) bytes per frame, where G is the input gap in cycles. No overflow occurs for G ≥ 20 with defaults.

## Configuration
- `GMII_TX_FRAMER_CNT_EN`:
  - Defined: `cnt_pkt` and `cnt_drop` are live registers as described.
  - Undefined: both outputs are tied to 0 and no counter logic is synthesized. Framing and truncation behaviour is unchanged.

## Structure
- Shared package constants:
  - PREAMBLE_BYTE 8'h55 and SFD_BYTE 8'hD5.
  - FSM state encoding: IDLE, PRE, SFD, DATA, IFG (3-bit).
  - The FIFO entry width, 10.
- One sub-module: `sync_byte_fifo`. It is a single-clock, synchronous-reset FIFO, parameterized by width and address width. It exposes a count output, uses registered read data, and has a first-word-fall-through read port.

## Test plan
- Single 64-byte frame 0x00..0x3F after reset:
  - Output shows 7×0x55, then 0xD5, then 0x00..0x3F.
  - `gmii_en_o` high for exactly 72 cycles, data byte 0 at T+11.
  - `cnt_pkt`=1.
- Two 60-byte frames with 20-cycle input gap:
  - Each output frame is correctly framed.
  - Exactly 12 idle cycles between them.
  - FIFO never exceeds 20 entries.
- Input byte 10 with `gmii_er_i`=1 → output byte 10 (cycle T+21) has `gmii_er_o`=1; all other bytes have er=0.
- 10 back-to-back 60-byte frames with 2-cycle gaps, FIFO_AW=6:
  - Overflow truncates a frame, whose final output byte has er=1.
  - `cnt_drop`≥1.
  - `cnt_pkt`+`cnt_drop`-truncated accounting matches the frames seen on the output.
  - No byte from a discarded tail appears.
- `rst` pulsed at output data byte 20 of a frame, while `gmii_dv_i` is still high:
  - Output goes idle next cycle.
  - Rest of the input frame ignored.
  - Next frame is framed correctly.
  - Counters read 0 then 1.
- Compile without `GMII_TX_FRAMER_CNT_EN` and rerun the first test → identical output waveform; `cnt_pkt`=`cnt_drop`=0.
